// File: rtl/sweep_pkg.sv
// Shared types and sizes for the sweep checker and its dwell timer.
package sweep_pkg;

   localparam int unsigned IDX_W   = 4;
   localparam int unsigned NUM_VEC = 16;
   localparam int unsigned ERR_W   = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/sweep_checker_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled; tc is high in the cycle the count sits at DWELL-1.
module dwell_timer
   import sweep_pkg::*;
#(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned CNT_W = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;

   // tc is registered by decoding the next count, so it lines up with cnt_q == LAST
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      tc_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         tc_q  <= (LAST == '0);
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign tc = tc_q;

endmodule

// File: rtl/sweep_checker.sv
// Exhaustive 4-input self-test: walks all 16 vectors, compares f/g against expected tables, reports results.
module sweep_checker
   import sweep_pkg::*;
#(
   parameter int unsigned DWELL = 4,
   parameter logic [15:0] EXP_F = 16'h0000,
   parameter logic [15:0] EXP_G = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   input  logic             f_in,
   input  logic             g_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [IDX_W-1:0] first_err_idx,
   output logic             first_err_valid
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] vec_q, vec_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [IDX_W-1:0] fidx_q, fidx_d;
   logic             fval_q, fval_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             timer_clr, timer_en, timer_tc;
   logic             mismatch;

   dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (timer_clr),
      .en  (timer_en),
      .tc  (timer_tc)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      err_d     = err_q;
      fidx_d    = fidx_q;
      fval_d    = fval_q;
      timer_clr = (state_q != DRIVE);
      timer_en  = (state_q == DRIVE);
      mismatch  = (f_in != EXP_F[idx_q]) || (g_in != EXP_G[idx_q]);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = DRIVE;
               idx_d   = '0;
               err_d   = '0;
               fidx_d  = '0;
               fval_d  = 1'b0;
            end
         end
         DRIVE: begin
            // One count per vector even when both f and g disagree
            if (timer_tc) begin
               if (mismatch) begin
                  err_d = err_q + ERR_W'(1);
                  if (!fval_q) begin
                     fidx_d = idx_q;
                     fval_d = 1'b1;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      vec_d  = (state_d == IDLE) ? '0 : idx_d;
      busy_d = (state_d == DRIVE);
      done_d = (state_d == DONE);
      pass_d = done_d && (err_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         err_q   <= '0;
         fidx_q  <= '0;
         fval_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         fidx_q  <= fidx_d;
         fval_q  <= fval_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign {a, b, c, d}    = vec_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_err_idx   = fidx_q;
   assign first_err_valid = fval_q;

endmodule

// File: tb/tb_sweep_checker.sv
// Scoreboard bench: two checkers (DWELL 4 and 1) beside a fault-injectable xor/and model.
module tb_sweep_checker;

   typedef struct {
      int err;
      int fidx;
      int fval;
      int pss;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic [1:0]  start_s = '0;
   logic [1:0]  rst_s   = '1;
   logic [15:0] fm_s [2];
   logic [15:0] gm_s [2];

   wire  [3:0] v0, v1;
   wire  [1:0] f_s, g_s, busy_s, done_s, pass_s, fval_s;
   wire  [4:0] err0, err1;
   wire  [3:0] fidx0, fidx1;

   exp_t sbq [2][$];
   bit   active [2];
   int   c0 [2];
   logic done_prev [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Unit under test model with per-vector fault masks
   assign f_s[0] = (^v0) ^ fm_s[0][v0];
   assign g_s[0] = (&v0) ^ gm_s[0][v0];
   assign f_s[1] = (^v1) ^ fm_s[1][v1];
   assign g_s[1] = (&v1) ^ gm_s[1][v1];

   sweep_checker #(.DWELL(4), .EXP_F(16'h6996), .EXP_G(16'h8000)) u4 (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]),
      .a(v0[3]), .b(v0[2]), .c(v0[1]), .d(v0[0]),
      .f_in(f_s[0]), .g_in(g_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
      .err_count(err0), .first_err_idx(fidx0), .first_err_valid(fval_s[0])
   );

   sweep_checker #(.DWELL(1), .EXP_F(16'h6996), .EXP_G(16'h8000)) u1 (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]),
      .a(v1[3]), .b(v1[2]), .c(v1[1]), .d(v1[0]),
      .f_in(f_s[1]), .g_in(g_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
      .err_count(err1), .first_err_idx(fidx1), .first_err_valid(fval_s[1])
   );

   function automatic int dwell_of(int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int vec_of(int i);
      return (i == 0) ? int'(v0) : int'(v1);
   endfunction

   function automatic int err_of(int i);
      return (i == 0) ? int'(err0) : int'(err1);
   endfunction

   function automatic int fidx_of(int i);
      return (i == 0) ? int'(fidx0) : int'(fidx1);
   endfunction

   task automatic chk(input string name, input int i, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[dut%0d] cyc=%0d: got %0d expected %0d", name, i, cyc, act, exp);
      end
   endtask

   // Reference: a vector fails if either output is faulted there
   function automatic exp_t model(input logic [15:0] fm, input logic [15:0] gm, input int done_cyc);
      exp_t e;
      logic [15:0] bad_vec;
      bad_vec = fm | gm;
      e.err = 0;
      e.fidx = 0;
      e.fval = 0;
      for (int k = 0; k < 16; k++) begin
         if (bad_vec[k]) begin
            e.err++;
            if (e.fval == 0) begin
               e.fidx = k;
               e.fval = 1;
            end
         end
      end
      e.pss = (e.err == 0) ? 1 : 0;
      e.cyc = done_cyc;
      return e;
   endfunction

   task automatic check_idle_state(input int i, input string tag);
      chk({tag, "_busy"}, i, int'(busy_s[i]), 0);
      chk({tag, "_done"}, i, int'(done_s[i]), 0);
      chk({tag, "_pass"}, i, int'(pass_s[i]), 0);
      chk({tag, "_err"}, i, err_of(i), 0);
      chk({tag, "_fidx"}, i, fidx_of(i), 0);
      chk({tag, "_fval"}, i, int'(fval_s[i]), 0);
      chk({tag, "_abcd"}, i, vec_of(i), 0);
   endtask

   task automatic start_sweep(input int i, input logic [15:0] fm, input logic [15:0] gm);
      @(negedge clk);
      fm_s[i] = fm;
      gm_s[i] = gm;
      start_s[i] = 1'b1;
      @(posedge clk);
      #1;
      start_s[i] = 1'b0;
      c0[i] = cyc;
      active[i] = 1'b1;
      sbq[i].push_back(model(fm, gm, cyc + 16 * dwell_of(i)));
   endtask

   task automatic wait_done(input int i);
      bit seen;
      seen = 0;
      for (int n = 0; n < 16 * dwell_of(i) + 8 && !seen; n++) begin
         @(negedge clk);
         if (done_s[i]) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_timeout[dut%0d] cyc=%0d: got done=0 expected done=1", i, cyc);
      end
   endtask

   task automatic do_reset(input int i);
      @(negedge clk);
      rst_s[i] = 1'b1;
      @(posedge clk);
      #1;
      active[i] = 1'b0;
      sbq[i].delete();
      @(negedge clk);
      rst_s[i] = 1'b0;
      check_idle_state(i, "rst");
   endtask

   // Monitor: per-cycle vector/busy alignment and scoreboard pop on done rising
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_s[i]) begin
            bit   exp_busy;
            exp_t e;
            exp_busy = active[i] && (cyc < c0[i] + 16 * dwell_of(i));
            chk("busy", i, int'(busy_s[i]), int'(exp_busy));
            if (exp_busy)
               chk("abcd", i, vec_of(i), (cyc - c0[i]) / dwell_of(i));
            if (done_s[i] && !done_prev[i]) begin
               if (sbq[i].size() == 0) begin
                  chk("unexpected_done", i, 1, 0);
               end else begin
                  e = sbq[i].pop_front();
                  chk("err_count", i, err_of(i), e.err);
                  chk("first_err_idx", i, fidx_of(i), e.fidx);
                  chk("first_err_valid", i, int'(fval_s[i]), e.fval);
                  chk("pass", i, int'(pass_s[i]), e.pss);
                  chk("done_cycle", i, cyc, e.cyc);
                  chk("abcd_done", i, vec_of(i), 15);
               end
            end
         end
         done_prev[i] = done_s[i];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         fm_s[i] = '0;
         gm_s[i] = '0;
         active[i] = 1'b0;
         c0[i] = 0;
         done_prev[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      // start together with rst: rst must win
      @(negedge clk);
      start_s = '1;
      @(negedge clk);
      start_s = '0;
      rst_s = '0;
      check_idle_state(0, "reset");
      check_idle_state(1, "reset");

      // Fault-free sweep, g stuck at 0, f inverted, f inverted plus g wrong on 15
      start_sweep(0, 16'h0000, 16'h0000); wait_done(0);
      start_sweep(0, 16'h0000, 16'h8000); wait_done(0);
      start_sweep(0, 16'hFFFF, 16'h0000); wait_done(0);
      start_sweep(0, 16'hFFFF, 16'h8000); wait_done(0);

      // Restart from DONE clears results
      start_sweep(0, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("restart_err", 0, err_of(0), 0);
      chk("restart_fval", 0, int'(fval_s[0]), 0);
      chk("restart_done", 0, int'(done_s[0]), 0);
      wait_done(0);

      // Reset mid-sweep, then a clean sweep
      start_sweep(0, 16'h0101, 16'h0000);
      repeat (29) @(posedge clk);
      do_reset(0);
      start_sweep(0, 16'h0000, 16'h0000); wait_done(0);

      // Start pulsed mid-sweep is ignored
      start_sweep(0, 16'h0420, 16'h0000);
      repeat (19) @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      wait_done(0);

      // DWELL=1 instance: clean, then faulted
      start_sweep(1, 16'h0000, 16'h0000); wait_done(1);
      start_sweep(1, 16'h8001, 16'h0010); wait_done(1);

      // Random fault patterns on both instances
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 2; i++) begin
            logic [15:0] fm, gm;
            fm = 16'($urandom) & 16'($urandom);
            gm = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if (r == 0) fm = '0;
            start_sweep(i, fm, gm);
            wait_done(i);
         end
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", 0, sbq[0].size(), 0);
      chk("sb_empty", 1, sbq[1].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sweep_checker.md
# sweep_checker

Self-test block that sweeps all 16 combinations of a 4-input combinational unit under test and checks its two outputs (f, g) against expected truth tables held as parameters. It sits beside the unit under test on the lab board/top level: it drives the unit's a, b, c, d inputs and samples its f, g outputs. It reports pass/fail, the mismatch count and the first failing vector, replacing manual waveform inspection with an in-hardware checker.

## Interface
- DWELL, 4: cycles each vector is held before sampling; legal range 1..255.
- EXP_F, 16'h0000: expected f; bit i is the expected f for vector index i.
- EXP_G, 16'h0000: expected g; bit i is the expected g for vector index i.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled in IDLE and DONE only.
- a  out  1  vector bit 3 (MSB).
- b  out  1  vector bit 2.
- c  out  1  vector bit 1.
- d  out  1  vector bit 0 (LSB).
- f_in  in  1  unit-under-test output f.
- g_in  in  1  unit-under-test output g.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete, results valid; held until next start or rst.
- pass  out  1  done and err_count == 0.
- err_count  out  5  number of mismatching vectors, 0..16.
- first_err_idx  out  4  index of first mismatching vector.
- first_err_valid  out  1  first_err_idx is meaningful.

## Operation
- States: IDLE, DRIVE, DONE.
- Vector mapping: {a,b,c,d} = idx, 4-bit, ascending 0..15 (0000 first, 1111 last).
- IDLE: {a,b,c,d}=0000, busy=0, done=0. On start=1 go to DRIVE, idx=0, dwell=0, and clear err_count, first_err_idx and first_err_valid.
- DRIVE: busy=1. dwell counts 0..DWELL-1. On the edge where dwell==DWELL-1:
  - Compare f_in vs EXP_F[idx] and g_in vs EXP_G[idx].
  - A mismatch on either output counts once: err_count+1.
  - If first_err_valid==0, capture first_err_idx=idx and set first_err_valid=1.
  - If idx==15, go to DONE. Otherwise idx+1 and dwell=0.
- DONE: busy=0, done=1, {a,b,c,d} held at 1111, results held. start=1 restarts the sweep exactly as from IDLE.
- start while in DRIVE is ignored.
- err_count maximum is 16. It fits in 5 bits, so no saturation logic is needed.
- Outputs a–d are registered. There is no combinational path from f_in/g_in to any output.

## Timing
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, state=IDLE.
- rst mid-sweep returns to IDLE on that edge, with all outputs at reset values. Partial results are discarded.
- Let E0 be the edge where start=1 is sampled.
  - busy=1 and vector 0 are visible after E0.
  - Vector k is driven from edge E0+k·DWELL to edge E0+(k+1)·DWELL.
  - Vector k is sampled at edge E0+(k+1)·DWELL.
- done/pass/err_count are final after edge E0+16·DWELL. busy falls on that same edge.
- Total sweep: 16·DWELL cycles.
- err_count updates on the sample edge, so intermediate values are visible while busy=1.
- start and rst asserted together: rst wins.

## Structure
- Package sweep_pkg holds:
  - state enum {IDLE, DRIVE, DONE};
  - IDX_W=4;
  - NUM_VEC=16;
  - ERR_W=5.
- One sub-module, dwell_timer: DWELL-parameterised counter with clear input and a terminal-count output `tc`. Width is $clog2(DWELL+1).
- FSM, idx register, comparison and result registers live in sweep_checker.

## Test plan
- Model DUT f=a^b^c^d, g=a&b&c&d; EXP_F=16'h6996, EXP_G=16'h8000, DWELL=4. Pulse start → after 64 cycles: done=1, pass=1, err_count=0, first_err_valid=0.
- Same setup with the model's g stuck at 0 → err_count=1, first_err_idx=15, first_err_valid=1, pass=0.
- Model f inverted → err_count=16, first_err_idx=0, pass=0. With f inverted and g also wrong on vector 15, err_count is still 16 (one count per vector).
- rst asserted at cycle 30 of a sweep → next cycle busy=0, all results 0, abcd=0000. A new start then completes normally in 64 cycles.
- start pulsed again at cycle 20 mid-sweep → ignored, done still arrives at cycle 64. start in DONE → results cleared and a second sweep passes.
- DWELL=1 → sweep takes 16 cycles. Check abcd steps every cycle in order 0..15 and matches the sample alignment.
